// File: rtl/mic_pkg.sv
// mic_pkg: shared types and default parameters for the microphone frame
// scheduler slice.
//   state_t          - scheduler FSM states
//   *_DEF            - default sample width, frame length and start watermark
package mic_pkg;

  localparam int DATA_WIDTH_DEF  = 24;
  localparam int FRAME_LEN_DEF   = 32;
  localparam int START_LEVEL_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/mic_skid_buf.sv
// mic_skid_buf: 2-entry output buffer behind a FIFO whose data_out is valid
// one cycle after the pop strobe. It tracks the single read that can be in
// flight and grants a credit only when the issued read is guaranteed a slot.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_rd_issue       a FIFO pop is issued this cycle
//   i_rd_data        FIFO data_out (valid the cycle after i_rd_issue)
//   o_credit_ok      a new read may be issued this cycle
//   o_valid/i_ready  downstream handshake
//   o_data           head-of-buffer sample
module mic_skid_buf
  import mic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rd_issue,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_credit_ok,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_pend;
  logic [1:0]            r_count;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;

  logic                  w_pop;
  logic                  w_push;
  logic [1:0]            w_committed;

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_head;
  assign w_pop   = o_valid & i_ready;
  assign w_push  = r_pend;

  // Slots still owed after this cycle's pop: counting the pop in the same
  // cycle is what lets a read issue every cycle while the consumer is ready.
  assign w_committed = r_count + 2'(r_pend) - 2'(w_pop);
  assign o_credit_ok = (w_committed < 2'd2);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend  <= 1'b0;
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_pend  <= i_rd_issue;
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_rd_data;
          else                 r_tail <= i_rd_data;
        end
        2'b01: r_head <= r_tail;
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= i_rd_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mic_frame_scheduler.sv
// mic_frame_scheduler: read-side controller for the microphone sample FIFO.
// Tracks FIFO occupancy from snooped pushes, waits for a start watermark,
// pops exactly one frame of FRAME_LEN samples and presents them on a
// valid/ready stream with first/last markers.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset (shared with FIFO)
//   i_enable              run request, honoured only between frames
//   i_clr_status          clears o_overflow
//   i_fifo_w_en           snooped FIFO push strobe
//   i_fifo_full/empty     FIFO flags
//   i_fifo_data           FIFO data_out, valid the cycle after o_fifo_r_en
//   o_fifo_r_en           FIFO pop strobe
//   o_m_valid/i_m_ready   output handshake
//   o_m_data              output sample
//   o_m_first/o_m_last    frame index 0 / FRAME_LEN-1 markers
//   o_busy                state is not IDLE
//   o_overflow            sticky push-while-full
//   o_frame_count         completed frames, wrapping
//
// state | meaning
// IDLE  | stopped, no reads
// WAIT  | armed, waiting for occupancy to reach START_LEVEL
// RUN   | issuing reads for the current frame
// FLUSH | all reads issued, draining until the last sample is accepted
module mic_frame_scheduler
  import mic_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int FRAME_LEN   = FRAME_LEN_DEF,
  parameter int START_LEVEL = START_LEVEL_DEF,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_clr_status,
  input  logic                  i_fifo_w_en,
  input  logic                  i_fifo_full,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_r_en,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_first,
  output logic                  o_m_last,
  output logic                  o_busy,
  output logic                  o_overflow,
  output logic [CNT_WIDTH-1:0]  o_frame_count
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [LVL_W-1:0]     r_level;
  logic [IDX_W-1:0]     r_req_cnt;
  logic [IDX_W-1:0]     r_out_idx;
  logic                 r_overflow;
  logic [CNT_WIDTH-1:0] r_frame_count;

  logic w_credit_ok;
  logic w_m_valid;
  logic w_rd;
  logic w_push_ok;
  logic w_hs;
  logic w_last_hs;
  logic w_last_req;

  mic_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rd_issue  (w_rd),
    .i_rd_data   (i_fifo_data),
    .o_credit_ok (w_credit_ok),
    .o_valid     (w_m_valid),
    .i_ready     (i_m_ready),
    .o_data      (o_m_data)
  );

  assign w_push_ok  = i_fifo_w_en & ~i_fifo_full;
  assign w_rd       = (r_state == RUN) & w_credit_ok & ~i_fifo_empty;
  assign w_last_req = w_rd & (r_req_cnt == LAST_IDX);
  assign w_hs       = w_m_valid & i_m_ready;
  assign w_last_hs  = w_hs & (r_out_idx == LAST_IDX);

  assign o_fifo_r_en   = w_rd;
  assign o_m_valid     = w_m_valid;
  assign o_m_first     = w_m_valid & (r_out_idx == '0);
  assign o_m_last      = w_m_valid & (r_out_idx == LAST_IDX);
  assign o_busy        = (r_state != IDLE);
  assign o_overflow    = r_overflow;
  assign o_frame_count = r_frame_count;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (i_enable) w_state_nxt = WAIT;
      WAIT: begin
        if (!i_enable)                              w_state_nxt = IDLE;
        else if (r_level >= LVL_W'(START_LEVEL))    w_state_nxt = RUN;
      end
      RUN:   if (w_last_req) w_state_nxt = FLUSH;
      FLUSH: if (w_last_hs)  w_state_nxt = i_enable ? WAIT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_level       <= '0;
      r_req_cnt     <= '0;
      r_out_idx     <= '0;
      r_overflow    <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state <= w_state_nxt;

      case ({w_push_ok, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: ;
      endcase

      if (w_rd) r_req_cnt <= w_last_req ? '0 : r_req_cnt + 1'b1;

      if (w_hs) r_out_idx <= (r_out_idx == LAST_IDX) ? '0 : r_out_idx + 1'b1;

      if (w_last_hs) r_frame_count <= r_frame_count + 1'b1;

      // A new push-while-full outranks a simultaneous clear.
      if (i_fifo_w_en & i_fifo_full) r_overflow <= 1'b1;
      else if (i_clr_status)         r_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mic_frame_scheduler.sv
module tb_mic_frame_scheduler;
  import mic_pkg::*;

  localparam int DW    = 24;
  localparam int FL    = 32;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          clr_status = 1'b0;
  logic          fifo_w_en = 1'b0;
  logic [DW-1:0] fifo_wdata = '0;
  logic          m_ready = 1'b0;
  logic          fifo_full, fifo_empty, fifo_r_en;
  logic [DW-1:0] fifo_data, m_data;
  logic          m_valid, m_first, m_last, busy, overflow;
  logic [15:0]   frame_count;

  always #5 clk = ~clk;

  mic_frame_scheduler dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_enable      (enable),
    .i_clr_status  (clr_status),
    .i_fifo_w_en   (fifo_w_en),
    .i_fifo_full   (fifo_full),
    .i_fifo_empty  (fifo_empty),
    .i_fifo_data   (fifo_data),
    .o_fifo_r_en   (fifo_r_en),
    .o_m_valid     (m_valid),
    .i_m_ready     (m_ready),
    .o_m_data      (m_data),
    .o_m_first     (m_first),
    .o_m_last      (m_last),
    .o_busy        (busy),
    .o_overflow    (overflow),
    .o_frame_count (frame_count)
  );

  // Behavioural FIFO: holds DEPTH-1 samples, registered data_out.
  logic [DW-1:0] fmem [DEPTH];
  int fcount = 0, fwp = 0, frp = 0;
  assign fifo_full  = (fcount == DEPTH - 1);
  assign fifo_empty = (fcount == 0);

  always @(posedge clk) begin
    if (rst) begin
      fcount    <= 0;
      fwp       <= 0;
      frp       <= 0;
      fifo_data <= '0;
    end else begin
      if (fifo_w_en && !fifo_full) begin
        fmem[fwp] <= fifo_wdata;
        fwp <= (fwp + 1) % DEPTH;
      end
      if (fifo_r_en && !fifo_empty) begin
        fifo_data <= fmem[frp];
        frp <= (frp + 1) % DEPTH;
      end
      fcount <= fcount + ((fifo_w_en && !fifo_full) ? 1 : 0)
                       - ((fifo_r_en && !fifo_empty) ? 1 : 0);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          f;
    logic          l;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor / scoreboard
  int   hs_total = 0, rd_total = 0, cur_run = 0, outst = 0;
  logic prev_hs = 1'b0, prev_stall = 1'b0;
  exp_t held = '0;
  exp_t got;
  exp_t want;

  always @(negedge clk) begin
    if (!rst) begin
      got = '{d: m_data, f: m_first, l: m_last};
      if (fifo_r_en) begin
        rd_total++;
        outst++;
        check("read_while_empty", fifo_empty, 0);
      end
      if (prev_stall) begin
        check("stall_valid_held", m_valid, 1);
        check("stall_data_held", got, held);
      end
      if (m_valid && m_ready) begin
        hs_total++;
        outst--;
        cur_run = prev_hs ? cur_run + 1 : 1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_sample actual=%0h required=none", m_data);
        end else begin
          want = exp_q.pop_front();
          check("sample", got, want);
        end
      end
      if (fifo_r_en) check("outstanding_le_2", (outst <= 2), 1);
      prev_hs    = m_valid && m_ready;
      prev_stall = m_valid && !m_ready;
      held       = got;
    end else begin
      prev_hs    = 1'b0;
      prev_stall = 1'b0;
      outst      = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  int last_push_cyc = 0;

  task automatic push_seq(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_w_en  = 1'b1;
      fifo_wdata = base + DW'(i);
      last_push_cyc = cyc;
      tick(1);
    end
    fifo_w_en = 1'b0;
  endtask

  task automatic exp_frame(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{d: base + DW'(i), f: (i == 0), l: (i == FL - 1)});
  endtask

  task automatic drain(input string name, input int budget, input bit toggle);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      if (toggle) m_ready = ~m_ready;
      tick(1);
      k++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int rd0, hs0, pc, rd_cyc, v_cyc;
  logic [DW-1:0] v_data;
  logic v_first;

  initial begin
    // Reset state
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          {fifo_r_en, m_valid, m_first, m_last, busy, overflow, frame_count, m_data}, 0);
    check("reset_level", dut.r_level, 0);
    @(posedge clk); #1;

    // Watermark: 15 samples do not start a frame, the 16th does
    enable  = 1'b1;
    m_ready = 1'b1;
    tick(2);
    check("wm_armed_wait", dut.r_state, WAIT);
    exp_frame(24'h000A00, FL);
    rd0 = rd_total;
    push_seq(24'h000A00, 15);
    tick(5);
    check("wm_no_read_below_level", rd_total - rd0, 0);
    check("wm_still_wait", dut.r_state, WAIT);
    push_seq(24'h000A0F, 1);
    pc = last_push_cyc;
    rd_cyc = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (fifo_r_en) begin
        rd_cyc = cyc;
        break;
      end
    end
    check("wm_first_read_cycle", rd_cyc, pc + 2);
    v_cyc = -1; v_data = '0; v_first = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_valid) begin
        v_cyc = cyc; v_data = m_data; v_first = m_first;
        break;
      end
    end
    check("wm_valid_latency", v_cyc, rd_cyc + 2);
    check("wm_first_flag", v_first, 1);
    check("wm_first_data", v_data, 24'h000A00);
    @(posedge clk); #1;
    push_seq(24'h000A10, 16);
    drain("wm_frame_drained", 300, 1'b0);
    check("wm_frame_count", frame_count, 1);

    // Throughput with 40 samples preloaded
    enable = 1'b0;
    do_reset();
    push_seq(24'h000B00, 40);
    check("tp_idle_no_reads", dut.r_state, IDLE);
    exp_frame(24'h000B00, FL);
    rd0 = rd_total; hs0 = hs_total;
    enable = 1'b1;
    drain("tp_frame_drained", 200, 1'b0);
    tick(3);
    check("tp_pops", rd_total - rd0, 32);
    check("tp_handshakes", hs_total - hs0, 32);
    check("tp_consecutive_run", cur_run, 32);
    check("tp_frame_count", frame_count, 1);
    check("tp_level_left", dut.r_level, 8);

    // Backpressure: m_ready toggles every cycle
    m_ready = 1'b0;
    do_reset();
    exp_frame(24'h000C00, FL);
    push_seq(24'h000C00, 32);
    drain("bp_frame_drained", 400, 1'b1);
    m_ready = 1'b1;
    tick(3);
    check("bp_frame_count", frame_count, 1);

    // Enable drop after sample 10
    m_ready = 1'b1;
    enable  = 1'b1;
    do_reset();
    exp_frame(24'h000D00, FL);
    rd0 = rd_total; hs0 = hs_total;
    fork
      push_seq(24'h000D00, 40);
      begin
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (hs_total - hs0 >= 10) break;
        end
        @(posedge clk); #1;
        enable = 1'b0;
      end
    join
    drain("ed_frame_drained", 200, 1'b0);
    tick(3);
    check("ed_busy_low", busy, 0);
    check("ed_state_idle", dut.r_state, IDLE);
    check("ed_frame_count", frame_count, 1);
    tick(10);
    check("ed_pops_exact", rd_total - rd0, 32);

    // Overflow
    enable = 1'b0;
    do_reset();
    push_seq(24'h000E00, 63);
    check("ov_clear_at_full", overflow, 0);
    check("ov_level_full", dut.r_level, 63);
    push_seq(24'h000E3F, 1);
    check("ov_set", overflow, 1);
    check("ov_level_sat", dut.r_level, 63);
    fifo_w_en = 1'b1; clr_status = 1'b1;
    tick(1);
    fifo_w_en = 1'b0; clr_status = 1'b0;
    check("ov_set_wins_clear", overflow, 1);
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
    check("ov_cleared", overflow, 0);

    // Reset in the middle of RUN after 7 samples
    enable  = 1'b1;
    m_ready = 1'b0;
    do_reset();
    exp_frame(24'h000F00, 7);
    push_seq(24'h000F00, 20);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_valid) break;
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    tick(7);
    m_ready = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("mr_outputs_zero",
          {fifo_r_en, m_valid, m_first, m_last, busy, overflow, frame_count, m_data}, 0);
    check("mr_level_zero", dut.r_level, 0);
    check("mr_partial_delivered", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    m_ready = 1'b1;
    exp_frame(24'h000700, FL);
    push_seq(24'h000700, 32);
    drain("mr_new_frame_drained", 200, 1'b0);
    check("mr_frame_count", frame_count, 1);

    tick(5);
    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mic_frame_scheduler.md
Name: mic_frame_scheduler

Overview:
Read-side controller for the microphone sample FIFO. It decides when to pop samples and groups them into fixed-length frames (FRAME_LEN samples) for the downstream feature-extraction stage, using a valid/ready handshake. It tracks FIFO occupancy by watching FIFO pushes, applies a start watermark before each frame, and reports overflow and completed-frame status.

Parameters:
DEPTH, 64, depth of the attached FIFO; the FIFO holds at most DEPTH-1 samples.
DATA_WIDTH, 24, sample width.
FRAME_LEN, 32, samples per frame; must be at least 2.
START_LEVEL, 16, occupancy required before a frame starts; legal range 1..min(FRAME_LEN, DEPTH-1).
CNT_WIDTH, 16, width of frame_count.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset; the same rst drives the FIFO.
enable  in  1  run request; sampled only at frame boundaries.
clr_status  in  1  clears overflow.
fifo_w_en  in  1  FIFO push strobe (snooped).
fifo_full  in  1  FIFO full flag.
fifo_empty  in  1  FIFO empty flag.
fifo_data  in  DATA_WIDTH  FIFO data_out, registered; valid the cycle after r_en.
fifo_r_en  out  1  FIFO pop strobe.
m_valid  out  1  output sample valid.
m_ready  in  1  downstream accept.
m_data  out  DATA_WIDTH  output sample.
m_first  out  1  marks sample index 0 of a frame.
m_last  out  1  marks sample index FRAME_LEN-1.
busy  out  1  high when the state is not IDLE.
overflow  out  1  sticky push-while-full flag.
frame_count  out  CNT_WIDTH  completed frames; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset: all outputs 0, state IDLE, level 0, req_cnt 0, out_idx 0, skid buffer empty.
- level counter, width clog2(DEPTH)+1:
  - +1 on fifo_w_en & !fifo_full.
  - -1 on fifo_r_en.
  - Unchanged when both occur in the same cycle.
- fifo_r_en = issue condition & !fifo_empty. It is never asserted while fifo_empty.
- Credit rule: a 2-entry skid buffer sits on the output. A read issues only if (entries held + reads in flight) < 2. This sustains 1 sample/cycle while m_ready is high.
- Latency:
  - fifo_r_en at cycle N; fifo_data is captured at the end of N+1; m_valid rises at N+2.
  - m_data, m_first and m_last hold stable while m_valid & !m_ready.
- States:
  - IDLE: no reads. Go to WAIT when enable=1.
  - WAIT: no reads. Go to RUN when level >= START_LEVEL. Go to IDLE if enable=0.
  - RUN: issue reads per the credit rule. req_cnt increments per read. When the read with req_cnt==FRAME_LEN-1 issues, go to FLUSH and clear req_cnt. enable is ignored in RUN, so frames are never truncated.
  - FLUSH: no reads. On the m_last handshake, go to WAIT if enable=1, else IDLE.
- Output framing:
  - out_idx increments on each handshake (m_valid & m_ready) and wraps to 0 after FRAME_LEN-1.
  - m_first = (out_idx==0); m_last = (out_idx==FRAME_LEN-1); both are qualified by m_valid.
- frame_count increments on the m_last handshake.
- FIFO empty mid-frame (underrun): reads stall and the frame continues when data arrives. Output has gaps but no lost or duplicated samples.
- overflow:
  - Set on fifo_w_en & fifo_full.
  - Cleared by clr_status.
  - Set wins when both occur in the same cycle.
- Reset mid-frame: the partial frame is discarded; the FIFO and this block restart empty together.

Decomposition:
- Package mic_pkg holds the state enum (IDLE, WAIT, RUN, FLUSH), DATA_WIDTH default, and FRAME_LEN/START_LEVEL defaults.
- Sub-module mic_skid_buf: 2-entry valid/ready buffer with an in-flight credit count.
- Level tracking, FSM and framing stay in the top module.

Test Plan:
- Reset and watermark: push 15 samples with enable=1 → fifo_r_en stays 0 and state stays WAIT. Push a 16th → first fifo_r_en, then m_valid 2 cycles later with m_first=1 and m_data = 1st sample.
- Throughput: pre-fill 40 samples, m_ready=1 constantly → 32 consecutive m_valid cycles. m_last falls on the 32nd sample, frame_count 0→1, and exactly 32 pops occur.
- Backpressure: toggle m_ready 1/0 every cycle → all 32 samples arrive in order with none duplicated, m_data is held while stalled, and never more than 2 reads are outstanding.
- Enable drop mid-frame: deassert enable after sample 10 → all 32 samples still delivered, then busy=0 and IDLE. The remaining FIFO contents are not read.
- Overflow: push 64 times with no reads → overflow=1 and level=63. Drive clr_status together with another push-while-full → overflow stays 1. clr_status alone → 0.
- Reset mid-RUN at sample 7: assert rst for 1 cycle → all outputs 0 and level 0. The next frame starts with m_first on the first sample pushed after reset.
